// File: rtl/udma_ptp_ts_reg_mch.sv
// Multi-channel cfg/status register file for the uDMA ptp ts RX path.
// Define PTP_TS_HWM_EN to add per-channel FIFO high-watermark tracking at offset 0x28.
module udma_ptp_ts_reg_mch #(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned RX_FIFO_DEPTH  = 1024,
    parameter int unsigned FLOG           = $clog2(RX_FIFO_DEPTH),
    parameter int unsigned CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [31:0]                    cfg_data_i,
    input  logic [5+CH_W-1:0]              cfg_addr_i,
    input  logic                           cfg_valid_i,
    input  logic                           cfg_rwn_i,
    output logic [31:0]                    cfg_data_o,
    output logic                           cfg_ready_o,
    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [N_CH-1:0]                cfg_rx_continuous_o,
    output logic [N_CH-1:0]                cfg_rx_en_o,
    output logic [N_CH-1:0]                cfg_rx_clr_o,
    input  logic [N_CH-1:0]                cfg_rx_en_i,
    input  logic [N_CH-1:0]                cfg_rx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    input  logic [N_CH*(FLOG+1)-1:0]       rx_fifo_elements_i,
    input  logic [N_CH-1:0]                rx_fifo_push_i,
    output logic [N_CH-1:0]                irq_o
);

    localparam int unsigned AW = L2_AWIDTH_NOAL;
    localparam int unsigned EW = FLOG + 1;

    localparam logic [4:0] RegSaddr   = 5'h00;
    localparam logic [4:0] RegSize    = 5'h01;
    localparam logic [4:0] RegCfg     = 5'h02;
    localparam logic [4:0] RegWhoami  = 5'h03;
    localparam logic [4:0] RegFifoCfg = 5'h07;
    localparam logic [4:0] RegFifoN   = 5'h08;
    localparam logic [4:0] RegFifoThr = 5'h09;
    localparam logic [4:0] RegFifoHwm = 5'h0A;

    logic [4:0]      reg_idx;
    logic [CH_W-1:0] ch_sel;
    logic            wr_en;

    assign reg_idx     = cfg_addr_i[4:0];
    assign ch_sel      = cfg_addr_i[5+:CH_W];
    assign wr_en       = cfg_valid_i & ~cfg_rwn_i;
    assign cfg_ready_o = 1'b1;

    logic [AW-1:0]         startaddr_q [N_CH];
    logic [TRANS_SIZE-1:0] size_q      [N_CH];
    logic [EW-1:0]         thr_q       [N_CH];
    logic [EW-1:0]         elem        [N_CH];
    logic [N_CH-1:0]       cont_q, en_q, clr_q, irq_en_q, ovf_q, irq_q;
    logic [N_CH-1:0]       full, wr_hit;

    // A channel select with no matching channel leaves wr_hit all-zero, so the write is dropped.
    always_comb begin
        full   = '0;
        wr_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            elem[c]   = rx_fifo_elements_i[c*EW +: EW];
            full[c]   = (elem[c] == EW'(RX_FIFO_DEPTH));
            wr_hit[c] = wr_en && (ch_sel == CH_W'(c));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_CH; c++) begin
                startaddr_q[c] <= '0;
                size_q[c]      <= '0;
                thr_q[c]       <= '0;
            end
            cont_q   <= '0;
            en_q     <= '0;
            clr_q    <= '0;
            irq_en_q <= '0;
            ovf_q    <= '0;
            irq_q    <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                en_q[c]  <= 1'b0;
                clr_q[c] <= 1'b0;
                if (wr_hit[c]) begin
                    case (reg_idx)
                        RegSaddr:   startaddr_q[c] <= cfg_data_i[AW-1:0];
                        RegSize:    size_q[c]      <= cfg_data_i[TRANS_SIZE-1:0];
                        RegCfg: begin
                            cont_q[c] <= cfg_data_i[0];
                            en_q[c]   <= cfg_data_i[4];
                            clr_q[c]  <= cfg_data_i[6];
                        end
                        RegFifoCfg: irq_en_q[c]    <= cfg_data_i[0];
                        RegFifoThr: thr_q[c]       <= cfg_data_i[EW-1:0];
                        default: ;
                    endcase
                end
                // A push into a full FIFO beats a same-cycle W1C.
                if (rx_fifo_push_i[c] && full[c]) begin
                    ovf_q[c] <= 1'b1;
                end else if (wr_hit[c] && (reg_idx == RegFifoCfg) && cfg_data_i[1]) begin
                    ovf_q[c] <= 1'b0;
                end
                irq_q[c] <= irq_en_q[c] &
                            (ovf_q[c] | ((thr_q[c] != '0) & (elem[c] >= thr_q[c])));
            end
        end
    end

`ifdef PTP_TS_HWM_EN
    logic [EW-1:0] hwm_q [N_CH];

    // A clear write restarts tracking from the current fill level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_CH; c++) hwm_q[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_hit[c] && (reg_idx == RegFifoHwm)) begin
                    hwm_q[c] <= elem[c];
                end else if (elem[c] > hwm_q[c]) begin
                    hwm_q[c] <= elem[c];
                end
            end
        end
    end
`endif

    always_comb begin
        cfg_data_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel == CH_W'(c)) begin
                case (reg_idx)
                    RegSaddr:   cfg_data_o = 32'(cfg_rx_curr_addr_i[c*AW +: AW]);
                    RegSize:    cfg_data_o = 32'(cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]);
                    RegCfg:     cfg_data_o = {26'd0, cfg_rx_pending_i[c], cfg_rx_en_i[c],
                                              3'd0, cont_q[c]};
                    RegWhoami:  cfg_data_o = 32'hDEADBEEF;
                    RegFifoCfg: cfg_data_o = {29'd0, full[c], ovf_q[c], irq_en_q[c]};
                    RegFifoN:   cfg_data_o = 32'(elem[c]);
                    RegFifoThr: cfg_data_o = 32'(thr_q[c]);
`ifdef PTP_TS_HWM_EN
                    RegFifoHwm: cfg_data_o = 32'(hwm_q[c]);
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rx_startaddr_o = '0;
        cfg_rx_size_o      = '0;
        for (int c = 0; c < N_CH; c++) begin
            cfg_rx_startaddr_o[c*AW +: AW]         = startaddr_q[c];
            cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE] = size_q[c];
        end
    end

    assign cfg_rx_continuous_o = cont_q;
    assign cfg_rx_en_o         = en_q;
    assign cfg_rx_clr_o        = clr_q;
    assign irq_o               = irq_q;

    logic unused_data;
    assign unused_data = ^cfg_data_i;

endmodule

// File: tb/tb_udma_ptp_ts_reg_mch.sv
// Self-checking bench for udma_ptp_ts_reg_mch with three channels, so index 3 is out of range.
// Expectations for offset 0x28 follow PTP_TS_HWM_EN.
module tb_udma_ptp_ts_reg_mch;

    localparam int unsigned NCh   = 3;
    localparam int unsigned Aw    = 12;
    localparam int unsigned Ts    = 16;
    localparam int unsigned Depth = 1024;
    localparam int unsigned Ew    = 11;
    localparam int unsigned NVec  = 19;
`ifdef PTP_TS_HWM_EN
    localparam bit HwmOn = 1'b1;
`else
    localparam bit HwmOn = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [1:0]  ch;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [31:0]       cfg_data;
    logic [6:0]        cfg_addr;
    logic              cfg_valid;
    logic              cfg_rwn;
    logic [31:0]       cfg_data_o;
    logic              cfg_ready_o;
    logic [NCh*Aw-1:0] startaddr_o;
    logic [NCh*Ts-1:0] size_o;
    logic [NCh-1:0]    cont_o, en_o, clr_o, irq_o;
    logic [NCh-1:0]    en_st, pending;
    logic [NCh*Aw-1:0] curr_addr;
    logic [NCh*Ts-1:0] bytes_left;
    logic [NCh*Ew-1:0] el;
    logic [NCh-1:0]    push;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    vec_t        vecs [NVec];

    always #5 clk = ~clk;

    udma_ptp_ts_reg_mch #(
        .N_CH          (NCh),
        .L2_AWIDTH_NOAL(Aw),
        .TRANS_SIZE    (Ts),
        .RX_FIFO_DEPTH (Depth)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .cfg_data_i         (cfg_data),
        .cfg_addr_i         (cfg_addr),
        .cfg_valid_i        (cfg_valid),
        .cfg_rwn_i          (cfg_rwn),
        .cfg_data_o         (cfg_data_o),
        .cfg_ready_o        (cfg_ready_o),
        .cfg_rx_startaddr_o (startaddr_o),
        .cfg_rx_size_o      (size_o),
        .cfg_rx_continuous_o(cont_o),
        .cfg_rx_en_o        (en_o),
        .cfg_rx_clr_o       (clr_o),
        .cfg_rx_en_i        (en_st),
        .cfg_rx_pending_i   (pending),
        .cfg_rx_curr_addr_i (curr_addr),
        .cfg_rx_bytes_left_i(bytes_left),
        .rx_fifo_elements_i (el),
        .rx_fifo_push_i     (push),
        .irq_o              (irq_o)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reads are combinational: push the expectation, settle, pop and compare.
    task automatic rd(input logic [1:0] ch, input logic [4:0] idx, input logic [31:0] exp,
                      input string name);
        exp_q.push_back(exp);
        cfg_addr  = {ch, idx};
        cfg_rwn   = 1'b1;
        cfg_valid = 1'b1;
        #1;
        chk(name, 64'(cfg_data_o), 64'(exp_q.pop_front()));
        cfg_valid = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [4:0] idx, input logic [31:0] data);
        cfg_addr  = {ch, idx};
        cfg_data  = data;
        cfg_rwn   = 1'b0;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_rwn   = 1'b1;
    endtask

    task automatic set_el(input int ch, input int val);
        el[ch*Ew +: Ew] = Ew'(val);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 5'd3,  32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd0, 5'd7,  32'h0,        32'h0};
        vecs[2]  = '{1'b0, 2'd0, 5'd0,  32'h0,        32'h123};
        vecs[3]  = '{1'b0, 2'd1, 5'd0,  32'h0,        32'h456};
        vecs[4]  = '{1'b0, 2'd2, 5'd1,  32'h0,        32'h3333};
        vecs[5]  = '{1'b0, 2'd0, 5'd2,  32'h0,        32'h30};
        vecs[6]  = '{1'b0, 2'd1, 5'd2,  32'h0,        32'h20};
        vecs[7]  = '{1'b0, 2'd2, 5'd2,  32'h0,        32'h10};
        vecs[8]  = '{1'b0, 2'd0, 5'd5,  32'h0,        32'h0};
        vecs[9]  = '{1'b0, 2'd2, 5'd8,  32'h0,        32'd77};
        vecs[10] = '{1'b1, 2'd1, 5'd9,  32'hFFFFFF07, 32'h707};
        vecs[11] = '{1'b1, 2'd0, 5'd9,  32'h10,       32'h10};
        vecs[12] = '{1'b0, 2'd3, 5'd3,  32'h0,        32'h0};
        vecs[13] = '{1'b1, 2'd3, 5'd9,  32'h55,       32'h0};
        vecs[14] = '{1'b0, 2'd0, 5'd9,  32'h0,        32'h10};
        vecs[15] = '{1'b0, 2'd1, 5'd9,  32'h0,        32'h707};
        vecs[16] = '{1'b0, 2'd2, 5'd9,  32'h0,        32'h0};
        vecs[17] = '{1'b0, 2'd0, 5'd10, 32'h0,        32'h0};
        vecs[18] = '{1'b0, 2'd2, 5'd10, 32'h0,        HwmOn ? 32'd77 : 32'd0};

        rstn       = 1'b0;
        cfg_data   = '0;
        cfg_addr   = '0;
        cfg_valid  = 1'b0;
        cfg_rwn    = 1'b1;
        en_st      = 3'b101;
        pending    = 3'b011;
        curr_addr  = {12'hABC, 12'h456, 12'h123};
        bytes_left = {16'h3333, 16'h2222, 16'h1111};
        el         = '0;
        push       = '0;

        #12;
        chk("rst_irq", 64'(irq_o), 64'h0);
        chk("rst_en", 64'(en_o), 64'h0);
        chk("rst_clr", 64'(clr_o), 64'h0);
        chk("rst_cont", 64'(cont_o), 64'h0);
        chk("rst_saddr", 64'(startaddr_o), 64'h0);
        chk("rst_size", 64'(size_o), 64'h0);
        chk("ready", 64'(cfg_ready_o), 64'h1);
        rstn = 1'b1;
        step();
        set_el(2, 77);
        step();

        for (int i = 0; i < NVec; i++) begin
            if (vecs[i].wr) wr(vecs[i].ch, vecs[i].idx, vecs[i].data);
            rd(vecs[i].ch, vecs[i].idx, vecs[i].exp, $sformatf("vec%0d", i));
            step();
        end

        // en/clr pulse for one cycle, cont holds, other channels untouched.
        wr(2'd1, 5'd2, 32'h51);
        chk("cfg_en_pulse", 64'(en_o), 64'h2);
        chk("cfg_clr_pulse", 64'(clr_o), 64'h2);
        chk("cfg_cont", 64'(cont_o), 64'h2);
        rd(2'd1, 5'd2, 32'h21, "cfg_rd");
        step();
        chk("cfg_en_gone", 64'(en_o), 64'h0);
        chk("cfg_clr_gone", 64'(clr_o), 64'h0);
        chk("cfg_cont_hold", 64'(cont_o), 64'h2);
        wr(2'd0, 5'd0, 32'hABCD);
        chk("saddr_out", 64'(startaddr_o), 64'h0BCD);
        wr(2'd1, 5'd1, 32'h12345);
        chk("size_out", 64'(size_o), 64'h0000_2345_0000);

        // Threshold interrupt on ch0.
        wr(2'd0, 5'd9, 32'd16);
        wr(2'd0, 5'd7, 32'h1);
        set_el(0, 15);
        step();
        step();
        chk("irq_below_thr", 64'(irq_o), 64'h0);
        set_el(0, 16);
        #1;
        chk("irq_not_yet", 64'(irq_o), 64'h0);
        step();
        chk("irq_at_thr", 64'(irq_o), 64'h1);
        set_el(0, 15);
        step();
        chk("irq_fall", 64'(irq_o), 64'h0);

        // Sticky overflow on ch0; set beats a same-cycle W1C.
        wr(2'd0, 5'd7, 32'h0);
        set_el(0, Depth);
        push = 3'b001;
        rd(2'd0, 5'd7, 32'h4, "full_no_ovf");
        step();
        push = 3'b000;
        rd(2'd0, 5'd7, 32'h6, "ovf_set");
        push = 3'b001;
        wr(2'd0, 5'd7, 32'h2);
        push = 3'b000;
        rd(2'd0, 5'd7, 32'h6, "ovf_set_wins");
        wr(2'd0, 5'd7, 32'h2);
        rd(2'd0, 5'd7, 32'h4, "ovf_w1c");
        rd(2'd1, 5'd7, 32'h0, "ovf_other_ch");

        // ch2: thr=0 disables the threshold term; overflow alone raises irq.
        wr(2'd2, 5'd7, 32'h1);
        set_el(2, Depth);
        step();
        step();
        chk("irq_thr0", 64'(irq_o), 64'h0);
        push = 3'b100;
        step();
        push = 3'b000;
        chk("irq_ovf_lat", 64'(irq_o), 64'h0);
        step();
        chk("irq_ovf", 64'(irq_o), 64'h4);

        // High watermark on ch1.
        set_el(1, 5);
        step();
        set_el(1, 40);
        step();
        set_el(1, 12);
        step();
        rd(2'd1, 5'd10, HwmOn ? 32'd40 : 32'd0, "hwm_max");
        wr(2'd1, 5'd10, 32'h0);
        rd(2'd1, 5'd10, HwmOn ? 32'd12 : 32'd0, "hwm_clear");
        set_el(1, 50);
        wr(2'd1, 5'd10, 32'h0);
        rd(2'd1, 5'd10, HwmOn ? 32'd50 : 32'd0, "hwm_clear_larger");
        rd(2'd0, 5'd10, HwmOn ? 32'd1024 : 32'd0, "hwm_ch0");
        rd(2'd1, 5'd8, 32'd50, "fifo_n");

        // Asynchronous reset in the middle of an enable pulse.
        wr(2'd1, 5'd2, 32'h51);
        chk("pre_rst_en", 64'(en_o), 64'h2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_en", 64'(en_o), 64'h0);
        chk("arst_clr", 64'(clr_o), 64'h0);
        chk("arst_cont", 64'(cont_o), 64'h0);
        chk("arst_irq", 64'(irq_o), 64'h0);
        chk("arst_saddr", 64'(startaddr_o), 64'h0);
        chk("arst_size", 64'(size_o), 64'h0);
        rd(2'd0, 5'd9, 32'h0, "arst_thr");
        #3;
        rstn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
